// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } state_t;

    localparam logic [31:0] NOP_INS          = 32'h0000_0000;
    localparam logic [29:0] RESET_PC_DEFAULT = 30'h2FF0_0000;  // byte 0xBFC0_0000

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory handshake bus: req/gnt address phase, rvalid data phase.
interface if_fetch_stage_if;

    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_perf_cnt.sv
// Fetch-stage performance counters: consumed instructions and stalled-valid cycles.
// Only compiled when IF_PERF_CNT_EN is defined.
`ifdef IF_PERF_CNT_EN
module if_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the word PC, one outstanding imem request at a time.
// Optional IF_PERF_CNT_EN adds fetch/stall performance counters.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hazard,
    input  logic                branch_bubble,
    input  logic                redirect_valid,
    input  logic [29:0]         redirect_pc,
    input  logic                exc_valid,
    input  logic [29:0]         exc_pc,
    if_fetch_stage_if.master    bus,
    output logic                if_valid,
    output logic [31:0]         if_ins,
    output logic [29:0]         pc_plus_4,
    output logic                if_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d, pc_inc, target;
    logic        kill_q, kill_d;
    logic        valid_d, capture;
    logic        stall, redirect;

    assign stall    = hazard | branch_bubble;
    assign redirect = exc_valid | redirect_valid;
    assign target   = exc_valid ? exc_pc : redirect_pc;
    assign pc_inc   = pc_q + 30'd1;

    // Request is gated by reset so nothing is issued while rst_n is low.
    assign bus.imem_req  = rst_n && (state_q == REQ);
    assign bus.imem_addr = pc_q;
    assign if_flush      = !if_valid;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        pc_d    = redirect ? target : pc_q;
        kill_d  = kill_q;
        valid_d = if_valid;
        capture = 1'b0;
        unique case (state_q)
            REQ: begin
                // A redirect that coincides with gnt orphans the in-flight fetch.
                if (bus.imem_gnt) begin
                    state_d = WAIT;
                    if (redirect) kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect) begin
                        capture = 1'b1;
                        pc_d    = pc_inc;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            if_valid  <= 1'b0;
            if_ins    <= NOP_INS;
            pc_plus_4 <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            if_valid <= valid_d;
            if (capture) begin
                if_ins    <= bus.imem_rdata;
                pc_plus_4 <= pc_inc;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    // A held instruction dropped by a redirect is not counted as fetched.
    if_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_inc (if_valid && !stall && !redirect),
        .stall_inc (if_valid && stall),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus reset/counter sequences.
// Define IF_PERF_CNT_EN to also exercise the performance counters.
module tb_if_fetch_stage;
    import if_pkg::*;

    typedef struct {
        logic        hazard;
        logic        bb;
        logic        rv;
        logic [29:0] rpc;
        logic        ev;
        logic [29:0] epc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [29:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ins;
        logic [29:0] e_p4;
    } vec_t;

    localparam logic [29:0] B    = 30'h2FF0_0000;
    localparam logic [31:0] I0   = 32'h2408_0001;
    localparam logic [31:0] I1   = 32'h2409_0002;
    localparam logic [31:0] I2   = 32'h012A_5820;
    localparam logic [31:0] I3   = 32'h8D0B_0004;
    localparam logic [31:0] I4   = 32'h1000_0003;
    localparam logic [31:0] I5   = 32'h3C01_BFC0;
    localparam logic [31:0] I6   = 32'hAC0B_0008;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hazard, branch_bubble, redirect_valid, exc_valid;
    logic [29:0] redirect_pc, exc_pc;
    logic        if_valid, if_flush;
    logic [31:0] if_ins;
    logic [29:0] pc_plus_4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    vec_t vecs[$];

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hazard         (hazard),
        .branch_bubble  (branch_bubble),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .bus            (bus),
        .if_valid       (if_valid),
        .if_ins         (if_ins),
        .pc_plus_4      (pc_plus_4),
        .if_flush       (if_flush)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic hz, input logic bb, input logic rv, input logic [29:0] rpc,
                       input logic ev, input logic [29:0] epc, input logic gnt, input logic rvalid,
                       input logic [31:0] rdata, input logic e_req, input logic [29:0] e_addr,
                       input logic e_valid, input logic [31:0] e_ins, input logic [29:0] e_p4);
        vec_t v;
        v = '{hz, bb, rv, rpc, ev, epc, gnt, rvalid, rdata, e_req, e_addr, e_valid, e_ins, e_p4};
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        hazard = 0; branch_bubble = 0; redirect_valid = 0; exc_valid = 0;
        redirect_pc = '0; exc_pc = '0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [29:0] e_addr,
                              input logic e_valid, input logic [31:0] e_ins, input logic [29:0] e_p4);
        check({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, e_req});
        check({tag, ".addr"},  {2'b0, bus.imem_addr}, {2'b0, e_addr});
        check({tag, ".valid"}, {31'd0, if_valid},     {31'd0, e_valid});
        check({tag, ".ins"},   if_ins,                e_ins);
        check({tag, ".p4"},    {2'b0, pc_plus_4},     {2'b0, e_p4});
        check({tag, ".flush"}, {31'd0, if_flush},     {31'd0, !e_valid});
    endtask

`ifdef IF_PERF_CNT_EN
    // One full zero-wait fetch, stalled for nstall cycles in HOLD before consumption.
    task automatic fetch_one(input logic [31:0] ins, input int nstall);
        bus.imem_gnt = 1;
        @(negedge clk);
        bus.imem_gnt = 0; bus.imem_rvalid = 1; bus.imem_rdata = ins;
        @(negedge clk);
        bus.imem_rvalid = 0; hazard = 1;
        for (int k = 0; k < nstall; k++) @(negedge clk);
        hazard = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        //   hz bb rv rpc            ev epc            gnt rvl rdata  req addr           vld ins p4
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, B,             0, '0, '0);
        add(0, 0, 0, '0,           0, '0,            0, 1, I0,    0, B,             0, '0, '0);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, B + 30'd1,     1, I0, B + 30'd1);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, B + 30'd1,     0, I0, B + 30'd1);
        add(0, 0, 0, '0,           0, '0,            0, 1, I1,    0, B + 30'd1,     0, I0, B + 30'd1);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, B + 30'd2,     1, I1, B + 30'd2);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, B + 30'd2,     0, I1, B + 30'd2);
        add(0, 0, 0, '0,           0, '0,            0, 1, I2,    0, B + 30'd2,     0, I1, B + 30'd2);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, B + 30'd3,     1, I2, B + 30'd3);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, B + 30'd3,     0, I2, B + 30'd3);
        add(0, 0, 0, '0,           0, '0,            0, 1, I3,    0, B + 30'd3,     0, I2, B + 30'd3);
        for (int k = 0; k < 4; k++)
            add(1, 0, 0, '0,       0, '0,            0, 0, '0,    0, B + 30'd4,     1, I3, B + 30'd4);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, B + 30'd4,     1, I3, B + 30'd4);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, B + 30'd4,     0, I3, B + 30'd4);
        add(0, 0, 1, 30'h100,      0, '0,            0, 0, '0,    0, B + 30'd4,     0, I3, B + 30'd4);
        add(0, 0, 0, '0,           0, '0,            0, 1, DEAD,  0, 30'h100,       0, I3, B + 30'd4);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, 30'h100,       0, I3, B + 30'd4);
        add(0, 0, 0, '0,           0, '0,            0, 1, I4,    0, 30'h100,       0, I3, B + 30'd4);
        add(0, 0, 1, 30'h100,      1, 30'h2000_0060, 0, 0, '0,    0, 30'h101,       1, I4, 30'h101);
        add(0, 0, 1, 30'h3FFF_FFFF, 0, '0,           0, 0, '0,    1, 30'h2000_0060, 0, I4, 30'h101);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, 30'h3FFF_FFFF, 0, I4, 30'h101);
        add(0, 0, 0, '0,           0, '0,            0, 1, I5,    0, 30'h3FFF_FFFF, 0, I4, 30'h101);
        add(0, 1, 0, '0,           0, '0,            0, 0, '0,    0, 30'h0,         1, I5, 30'h0);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, 30'h0,         1, I5, 30'h0);
        add(0, 0, 0, '0,           0, '0,            0, 1, DEAD,  1, 30'h0,         0, I5, 30'h0);
        add(0, 0, 0, '0,           0, '0,            1, 0, '0,    1, 30'h0,         0, I5, 30'h0);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, 30'h0,         0, I5, 30'h0);
        add(0, 0, 0, '0,           0, '0,            0, 1, I6,    0, 30'h0,         0, I5, 30'h0);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    0, 30'h1,         1, I6, 30'h1);
        add(0, 0, 1, 30'h200,      0, '0,            1, 0, '0,    1, 30'h1,         0, I6, 30'h1);
        add(0, 0, 0, '0,           0, '0,            0, 1, DEAD,  0, 30'h200,       0, I6, 30'h1);
        add(0, 0, 0, '0,           0, '0,            0, 0, '0,    1, 30'h200,       0, I6, 30'h1);

        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outs("reset", 1'b0, B, 1'b0, NOP_INS, 30'h0);
        rst_n = 1;

        foreach (vecs[i]) begin
            hazard         = vecs[i].hazard;
            branch_bubble  = vecs[i].bb;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            exc_valid      = vecs[i].ev;
            exc_pc         = vecs[i].epc;
            bus.imem_gnt    = vecs[i].gnt;
            bus.imem_rvalid = vecs[i].rvalid;
            bus.imem_rdata  = vecs[i].rdata;
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_valid, vecs[i].e_ins, vecs[i].e_p4);
            @(negedge clk);
        end

        // Reset asserted for one cycle while a fetch is outstanding; the late response is dropped.
        idle_inputs();
        bus.imem_gnt = 1;
        #1 check("rw.req0", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        bus.imem_gnt = 0;
        rst_n = 0;
        #1 check("rw.req_in_reset", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        bus.imem_rvalid = 1; bus.imem_rdata = DEAD;
        #1 check_outs("rw.after", 1'b1, B, 1'b0, NOP_INS, 30'h0);
        @(negedge clk);
        bus.imem_rvalid = 0; bus.imem_gnt = 1;
        #1 check_outs("rw.still", 1'b1, B, 1'b0, NOP_INS, 30'h0);
        @(negedge clk);
        bus.imem_gnt = 0; bus.imem_rvalid = 1; bus.imem_rdata = I0;
        @(negedge clk);
        bus.imem_rvalid = 0;
        #1 check_outs("rw.fetch", 1'b0, B + 30'd1, 1'b1, I0, B + 30'd1);
        @(negedge clk);

`ifdef IF_PERF_CNT_EN
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        #1;
        check("perf.fetch_reset", perf_fetch_cnt, 32'd0);
        check("perf.stall_reset", perf_stall_cnt, 32'd0);
        for (int k = 0; k < 10; k++) fetch_one(I0 + k, (k == 2) ? 2 : ((k == 7) ? 1 : 0));
        #1;
        check("perf.fetch", perf_fetch_cnt, 32'd10);
        check("perf.stall", perf_stall_cnt, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
